gbox_clk_data_pipe: RTL and testbench

GBOX_CLK_DATA_PIPE -- requirements
Module: gbox_clk_data_pipe

---
 rtl/gbox_clk_data_pipe.sv | 125 ++++++++++++
 tb/tb_gbox_clk_data_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gbox_clk_data_pipe.sv
// gbox_clk_data_pipe: DEPTH-stage enabled capture pipeline whose output is
// combined with a clock-derived gate signal before driving an O_BUFT.
// Optional feature macro: GBOX_CLK_DIV_EN -- when defined, the gate is a
// divided clock (period DIV clk cycles, 50% duty); when undefined, the gate
// is the clk net itself, used directly as data with no buffer in that path.
module gbox_clk_data_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             dout_oe
);

    localparam int FILL_W = (DEPTH > 1) ? $clog2(DEPTH + 1) : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    // DIV only shapes hardware with the divider built in, but an illegal
    // value is rejected in every build so configurations stay portable.
    if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_div_check
        $error("gbox_clk_data_pipe: DIV must be even and >= 2");
    end

    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  stage_d [DEPTH];
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [1:0]        mode_q;
    logic [WIDTH-1:0]  pipe_out;
    logic              clk_gate;

    // Next-state for the pipeline and fill counter: both move only when en=1.
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Pipeline stages, fill counter and mode register; mode is sampled every
    // edge regardless of en so a mode change lands exactly one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            fill_q <= '0;
            mode_q <= 2'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            fill_q <= fill_d;
            mode_q <= mode;
        end
    end

    assign pipe_out = stage_q[DEPTH-1];

`ifdef GBOX_CLK_DIV_EN
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic             clk_div_q;
    logic             clk_div_d;

    // Free-running half-period counter; clk_div flips each time it wraps.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        clk_div_d = clk_div_q;
        if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
            clk_div_d = ~clk_div_q;
        end
    end

    // Divider state register, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            clk_div_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign clk_gate = clk_div_q;
`else
    assign clk_gate = clk;
`endif

    assign dout_valid = (fill_q == FILL_FULL);
    assign dout_oe    = dout_valid;

    // Output combine: gate the pipeline output by mode; blank while not full.
    always_comb begin
        dout = '0;
        if (dout_valid) begin
            case (mode_q)
                2'd0:    dout = pipe_out & {WIDTH{clk_gate}};
                2'd1:    dout = pipe_out ^ {WIDTH{clk_gate}};
                2'd2:    dout = pipe_out;
                default: dout = {WIDTH{clk_gate}};
            endcase
        end
    end

endmodule

// File: tb/tb_gbox_clk_data_pipe.sv
// Directed bench for gbox_clk_data_pipe (WIDTH=4, DEPTH=2, DIV=4).
// Builds with or without GBOX_CLK_DIV_EN; gate-dependent expectations use a
// bench-side gate model (clk level, or an independent divide-by-4 model).
module tb_gbox_clk_data_pipe;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int DIV   = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_oe;

  int tests;
  int fails;

  gbox_clk_data_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .en         (en),
    .mode       (mode),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_oe    (dout_oe)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gate reference: the expected value of the DUT's internal clk_gate
  logic gate_m;
`ifdef GBOX_CLK_DIV_EN
  int div_cnt_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_m <= 0;
      gate_m    <= 1'b0;
    end else if (div_cnt_m == DIV / 2 - 1) begin
      div_cnt_m <= 0;
      gate_m    <= ~gate_m;
    end else begin
      div_cnt_m <= div_cnt_m + 1;
    end
  end
`else
  assign gate_m = clk;
`endif

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] exp_v;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    din   = '0;
    mode  = 2'd2;

    // reset state
    #12;
    check("rst_dout", dout, 4'h0);
    check("rst_valid", {3'b0, dout_valid}, 4'h0);
    check("rst_oe", {3'b0, dout_oe}, 4'h0);

    // fill with A then 5 in mode 2
    rst_n = 1'b1;
    en    = 1'b1;
    din   = 4'hA;
    tick();
    check("fill1_valid", {3'b0, dout_valid}, 4'h0);
    check("fill1_dout", dout, 4'h0);
    din = 4'h5;
    tick();
    check("fill2_valid", {3'b0, dout_valid}, 4'h1);
    check("fill2_dout", dout, 4'hA);
    din = 4'h3;
    tick();
    check("fill3_dout", dout, 4'h5);
    check("fill3_oe", {3'b0, dout_oe}, 4'h1);

    // hold: en=0 for 5 edges
    en  = 1'b0;
    din = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_dout", dout, 4'h5);
      check("hold_valid", {3'b0, dout_valid}, 4'h1);
    end
    half();
    check("hold_dout_lo", dout, 4'h5);

    // mode change 2 -> 1 with pipe_out = 3
    en  = 1'b1;
    din = 4'h3;
    tick();
    check("m21_pre", dout, 4'h3);
    en   = 1'b0;
    mode = 2'd1;
    half();
    check("m21_persist", dout, 4'h3);
    tick();
    exp_v = 4'h3 ^ {WIDTH{gate_m}};
    check("m21_xor_a", dout, exp_v);
    half();
    exp_v = 4'h3 ^ {WIDTH{gate_m}};
    check("m21_xor_b", dout, exp_v);

    // mode 0 with pipe_out = C
    mode = 2'd0;
    en   = 1'b1;
    din  = 4'hC;
    tick();
    tick();
    en = 1'b0;
    exp_v = 4'hC & {WIDTH{gate_m}};
    check("m0_a", dout, exp_v);
`ifndef GBOX_CLK_DIV_EN
    check("m0_clk_hi", dout, 4'hC);
`endif
    half();
    exp_v = 4'hC & {WIDTH{gate_m}};
    check("m0_b", dout, exp_v);
`ifndef GBOX_CLK_DIV_EN
    check("m0_clk_lo", dout, 4'h0);
`endif

    // mode 3: output is the gate itself
    mode = 2'd3;
    tick();
    exp_v = {WIDTH{gate_m}};
    check("m3_a", dout, exp_v);
    half();
    exp_v = {WIDTH{gate_m}};
    check("m3_b", dout, exp_v);

    // reset mid-stream with en=1, din=F
    mode = 2'd2;
    en   = 1'b1;
    din  = 4'hF;
    tick();
    tick();
    check("pre_rst_dout", dout, 4'hF);
    rst_n = 1'b0;
    #1;
    check("midrst_dout", dout, 4'h0);
    check("midrst_valid", {3'b0, dout_valid}, 4'h0);
    check("midrst_oe", {3'b0, dout_oe}, 4'h0);
    half();
    rst_n = 1'b1;
    tick();
    check("refill1_valid", {3'b0, dout_valid}, 4'h0);
    check("refill1_dout", dout, 4'h0);
    tick();
    check("refill2_valid", {3'b0, dout_valid}, 4'h1);
    check("refill2_dout", dout, 4'hF);

`ifdef GBOX_CLK_DIV_EN
    // divided gate in mode 3 from a fresh reset: 0, F, F, 0, 0, F
    half();
    rst_n = 1'b0;
    mode  = 2'd3;
    en    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    begin
      logic [WIDTH-1:0] div_exp [6];
      div_exp[0] = 4'h0;
      div_exp[1] = 4'hF;
      div_exp[2] = 4'hF;
      div_exp[3] = 4'h0;
      div_exp[4] = 4'h0;
      div_exp[5] = 4'hF;
      for (int i = 0; i < 6; i++) begin
        tick();
        check("div_m3", dout, div_exp[i]);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
